bp_update_scheduler: RTL
========================

Name: bp_update_scheduler

Overview:
- Sequences all writes into the branch predictor's 2-bit pattern history table (PHT) and owns the history recovery path.
- Tracks in-flight predictions in a small ordered queue from fetch through ALU resolution.
- Produces saturating counter training writes, misprediction flush, and GHR restore commands.
- After reset, sweeps the whole PHT to weakly-taken before accepting any prediction.

Parameters:
- GHR_SIZE, 8, PHT index width; table holds 2**GHR_SIZE entries.
- DEPTH, 4, in-flight prediction queue entries (power of two, >=2).
- FLUSH_CYCLES, 2, cycles spent in FLUSH after a misprediction (>=1).

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Pred_valid  in  1  fetch issued a prediction this cycle.
- i_Pred_index  in  GHR_SIZE  PHT index used for the prediction.
- i_Pred_ctr  in  2  counter value read at prediction time.
- i_Pred_ghr  in  GHR_SIZE  GHR snapshot before the speculative shift.
- o_Pred_ready  out  1  queue can accept a push.
- i_Res_valid  in  1  ALU resolves the oldest in-flight branch.
- i_Res_taken  in  1  actual outcome.
- o_Pht_we  out  1  PHT write enable.
- o_Pht_waddr  out  GHR_SIZE  PHT write index.
- o_Pht_wdata  out  2  PHT write data.
- o_Flush  out  1  one-cycle pulse; squash younger fetch.
- o_Ghr_restore  out  1  one-cycle pulse; load o_Ghr_value into the GHR.
- o_Ghr_value  out  GHR_SIZE  corrected history.
- o_Init_done  out  1  high once the sweep completes.
- o_Err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, any state): state=INIT, sweep counter=0, queue empty, all pulses 0, o_Pred_ready=0, o_Init_done=0, o_Err=0.
- INIT: each cycle o_Pht_we=1, o_Pht_waddr=sweep counter, o_Pht_wdata=2'b10; counter increments. After index 2**GHR_SIZE-1 is written (256 cycles at default), go to RUN and set o_Init_done=1. Pred/Res inputs are ignored in INIT.
- RUN, push:
  - o_Pred_ready = !full.
  - i_Pred_valid && o_Pred_ready enqueues {index, ctr, predicted=ctr[1], ghr}.
  - Push while full is dropped and sets o_Err.
- RUN, pop:
  - i_Res_valid pops the head.
  - Pop while empty is ignored and sets o_Err.
  - Simultaneous push and pop is legal: count unchanged, and a full queue accepts the push.
- Training (registered, 1 cycle after pop):
  - o_Pht_we=1, o_Pht_waddr=head.index.
  - o_Pht_wdata = taken ? min(ctr+1,3) : max(ctr-1,0), saturating with no wrap.
  - Stale ctr for repeated indices is accepted; last write wins.
- Mispredict (i_Res_taken != head.predicted), 1 cycle after pop, alongside the training write:
  - o_Flush=1 and o_Ghr_restore=1.
  - o_Ghr_value={head.ghr[GHR_SIZE-2:0], i_Res_taken}.
  - Queue cleared, including any push in the pop cycle.
  - State goes to FLUSH.
- FLUSH: o_Pred_ready=0; Pred and Res inputs are ignored (i_Res_valid here sets o_Err); lasts FLUSH_CYCLES cycles, then RUN.
- The PHT write port has a single owner per state (INIT sweep or RUN/FLUSH training), so no arbitration collision is possible.
- Queue pointers wrap modulo DEPTH; full/empty are derived from a count of width clog2(DEPTH)+1.

Decomposition:
- Package bp_pkg:
  - State encoding INIT/RUN/FLUSH.
  - Counter constants CTR_WEAK_T=2'b10, CTR_MAX=2'b11, CTR_MIN=2'b00.
  - Queue entry struct {index, ctr, predicted, ghr}.
- Sub-module bp_inflight_fifo: parameterised synchronous FIFO with push, pop, and clear, full/empty outputs, and async reset.
- The FSM, saturating arithmetic, and output registers stay in bp_update_scheduler.

Test Plan:
- Reset release -> o_Pht_we high for exactly 256 cycles with waddr 0..255 and wdata 2'b10; o_Init_done rises on cycle 257; o_Pred_ready=1.
- Push {idx=8'h12, ctr=3, ghr=8'hA5}, then resolve taken -> next cycle we=1, waddr=8'h12, wdata=3 (saturated); no flush.
- Push {idx=8'h40, ctr=1, ghr=8'h0F}, then resolve taken (mispredict) -> wdata=2, o_Flush=1, o_Ghr_restore=1, o_Ghr_value=8'h1F; o_Pred_ready=0 for 2 cycles.
- Push 4 entries -> o_Pred_ready=0. Simultaneous push+pop accepted (count stays 4). A 5th push alone sets o_Err.
- Three in flight, oldest mispredicts while a push arrives the same cycle -> queue empty after the flush. A later i_Res_valid sets o_Err.
- Assert i_Reset mid-FLUSH with the queue non-empty -> outputs clear immediately, and the sweep restarts at address 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor update path:
// scheduler states, 2-bit counter constants and the in-flight entry.
package bp_pkg;

  localparam int GHR_W = 8;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } state_t;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;
  localparam logic [1:0] CTR_MAX    = 2'b11;
  localparam logic [1:0] CTR_MIN    = 2'b00;

  typedef struct packed {
    logic [GHR_W-1:0] index;
    logic [1:0]       ctr;
    logic             predicted;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  function automatic logic [1:0] ctr_train(
    input logic [1:0] ctr,
    input logic       taken
  );
    if (taken)
      return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Ordered queue of in-flight predictions; clear wins over push/pop.
// A full queue still takes a push when a pop happens in the same cycle.
module bp_inflight_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic         i_Push,
  input  logic         i_Pop,
  input  logic         i_Clear,
  input  logic [W-1:0] i_Wdata,
  output logic [W-1:0] o_Rdata,
  output logic         o_Full,
  output logic         o_Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign o_Full  = (count == (AW+1)'(DEPTH));
  assign o_Empty = (count == '0);
  assign do_pop  = i_Pop && !o_Empty;
  assign do_push = i_Push && (!o_Full || do_pop);
  assign o_Rdata = mem[rd_ptr];

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push && !i_Clear) mem[wr_ptr] <= i_Wdata;
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Owns the PHT write port (init sweep, training) and the
// misprediction flush / GHR restore path.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int GHR_SIZE     = GHR_W,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Pred_valid,
  input  logic [GHR_SIZE-1:0] i_Pred_index,
  input  logic [1:0]          i_Pred_ctr,
  input  logic [GHR_SIZE-1:0] i_Pred_ghr,
  output logic                o_Pred_ready,
  input  logic                i_Res_valid,
  input  logic                i_Res_taken,
  output logic                o_Pht_we,
  output logic [GHR_SIZE-1:0] o_Pht_waddr,
  output logic [1:0]          o_Pht_wdata,
  output logic                o_Flush,
  output logic                o_Ghr_restore,
  output logic [GHR_SIZE-1:0] o_Ghr_value,
  output logic                o_Init_done,
  output logic                o_Err
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int EW = $bits(entry_t);

  state_t        state;
  logic [GHR_SIZE:0] sweep;
  logic [FW-1:0] flush_cnt;
  entry_t        push_e;
  entry_t        head;
  logic [EW-1:0] head_bits;
  logic          full;
  logic          empty;
  logic          in_run;
  logic          pop_ok;
  logic          mispredict;

  assign in_run       = (state == RUN);
  assign o_Pred_ready = in_run && !full;
  assign head         = entry_t'(head_bits);
  assign pop_ok       = in_run && i_Res_valid && !empty;
  assign mispredict   = pop_ok && (i_Res_taken != head.predicted);

  always_comb begin
    push_e           = '0;
    push_e.index     = i_Pred_index;
    push_e.ctr       = i_Pred_ctr;
    push_e.predicted = i_Pred_ctr[1];
    push_e.ghr       = i_Pred_ghr;
  end

  bp_inflight_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Push  (in_run && i_Pred_valid),
    .i_Pop   (in_run && i_Res_valid),
    .i_Clear (mispredict),
    .i_Wdata (push_e),
    .o_Rdata (head_bits),
    .o_Full  (full),
    .o_Empty (empty)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= INIT;
      sweep         <= '0;
      flush_cnt     <= '0;
      o_Pht_we      <= 1'b0;
      o_Pht_waddr   <= '0;
      o_Pht_wdata   <= '0;
      o_Flush       <= 1'b0;
      o_Ghr_restore <= 1'b0;
      o_Ghr_value   <= '0;
      o_Init_done   <= 1'b0;
      o_Err         <= 1'b0;
    end else begin
      o_Pht_we      <= 1'b0;
      o_Flush       <= 1'b0;
      o_Ghr_restore <= 1'b0;
      unique case (state)
        INIT: begin
          // MSB of sweep marks that the last index was written
          if (sweep[GHR_SIZE]) begin
            state       <= RUN;
            o_Init_done <= 1'b1;
          end else begin
            o_Pht_we    <= 1'b1;
            o_Pht_waddr <= sweep[GHR_SIZE-1:0];
            o_Pht_wdata <= CTR_WEAK_T;
            sweep       <= sweep + 1'b1;
          end
        end
        RUN: begin
          if ((i_Pred_valid && full && !i_Res_valid) ||
              (i_Res_valid && empty))
            o_Err <= 1'b1;
          if (pop_ok) begin
            o_Pht_we    <= 1'b1;
            o_Pht_waddr <= head.index;
            o_Pht_wdata <= ctr_train(head.ctr, i_Res_taken);
          end
          if (mispredict) begin
            o_Flush       <= 1'b1;
            o_Ghr_restore <= 1'b1;
            o_Ghr_value   <= {head.ghr[GHR_SIZE-2:0], i_Res_taken};
            state         <= FLUSH;
            flush_cnt     <= FW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (i_Res_valid) o_Err <= 1'b1;
          if (flush_cnt == '0) state <= RUN;
          else flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
